// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arbiter
// Purpose  : Per-channel rising/falling edge detection with one pending event
//            per channel, serialised round-robin onto a valid/ready port.
//            Define EDGE_ARB_B2B_EN for back-to-back grants (one event/cycle).
// Revision : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] a_in,
  input  logic [NUM_CH-1:0] pos_en,
  input  logic [NUM_CH-1:0] neg_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDX_W-1:0]  evt_ch,
  output logic              evt_pol,
  output logic [NUM_CH-1:0] ovf,
  input  logic [NUM_CH-1:0] ovf_clr
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] c_LAST_CH = IDX_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic [NUM_CH-1:0] prev_q, prev_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] pol_q, pol_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  evt_ch_q, evt_ch_d;
  logic              evt_valid_q, evt_valid_d;
  logic              evt_pol_q, evt_pol_d;

  logic [NUM_CH-1:0] w_rise, w_fall, w_edge, w_accept, w_grant_oh;
  logic [IDX_W-1:0]  w_hi_idx, w_lo_idx, w_grant_idx;
  logic              w_hi_found, w_lo_found, w_do_grant;

  // The first cycle after reset only captures a_in so a level held high
  // through reset is never mistaken for a rising edge.
  always_comb begin
    prev_d  = a_in;
    armed_d = 1'b1;
    w_rise  = armed_q ? (a_in & ~prev_q & pos_en) : '0;
    w_fall  = armed_q ? (~a_in & prev_q & neg_en) : '0;
    w_edge  = w_rise | w_fall;
  end

  // Round-robin: lowest pending index at or above rr, otherwise wrap to the
  // lowest pending index overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        if (IDX_W'(i) >= rr_q) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDX_W'(i);
        end
        w_lo_found = 1'b1;
        w_lo_idx   = IDX_W'(i);
      end
    end
    w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_pol_d   = evt_pol_q;
    rr_d        = rr_q;
    w_do_grant  = 1'b0;
    case (state_q)
      IDLE: begin
        w_do_grant = w_lo_found;
      end
      OFFER: begin
        if (evt_ready) begin
`ifdef EDGE_ARB_B2B_EN
          if (w_lo_found) begin
            w_do_grant = 1'b1;
          end else begin
            evt_valid_d = 1'b0;
            state_d     = IDLE;
          end
`else
          evt_valid_d = 1'b0;
          state_d     = IDLE;
`endif
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    if (w_do_grant) begin
      evt_valid_d = 1'b1;
      evt_ch_d    = w_grant_idx;
      evt_pol_d   = pol_q[w_grant_idx];
      rr_d        = (w_grant_idx == c_LAST_CH) ? '0 : w_grant_idx + IDX_W'(1);
      state_d     = OFFER;
    end
  end

  // A channel being granted this cycle frees its slot, so a simultaneous new
  // edge on it is accepted instead of counted as overflow.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_grant_oh[i] = w_do_grant && (w_grant_idx == IDX_W'(i));
    end
    w_accept  = w_edge & (~pending_q | w_grant_oh);
    pending_d = (pending_q & ~w_grant_oh) | w_accept;
    pol_d     = (pol_q & ~w_accept) | (w_rise & w_accept);
    ovf_d     = (ovf_q & ~ovf_clr) | (w_edge & pending_q & ~w_grant_oh);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      prev_q      <= '0;
      pending_q   <= '0;
      pol_q       <= '0;
      ovf_q       <= '0;
      rr_q        <= '0;
      evt_ch_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_pol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      pol_q       <= pol_d;
      ovf_q       <= ovf_d;
      rr_q        <= rr_d;
      evt_ch_q    <= evt_ch_d;
      evt_valid_q <= evt_valid_d;
      evt_pol_q   <= evt_pol_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_pol   = evt_pol_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_arbiter
// Purpose  : Scoreboard bench for edge_event_arbiter (default build, with the
//            bubble cycle after each handshake).
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] a_in;
  logic [3:0] pos_en;
  logic [3:0] neg_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_pol;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;

  typedef struct {
    logic [1:0] ch;
    logic       pol;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  edge_event_arbiter #(.NUM_CH(4), .IDX_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .pos_en    (pos_en),
    .neg_en    (neg_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_pol   (evt_pol),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic pol);
    exp_t e;
    e.ch  = ch;
    e.pol = pol;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic count_valid(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (evt_valid) c++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || evt_valid) && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_done", sb_q.size(), 0);
    tick(2);
  endtask

  // Output monitor: handshakes pop the scoreboard, offers must hold stable.
  logic       hold_chk = 1'b0;
  logic       hs_prev  = 1'b0;
  logic [1:0] held_ch;
  logic       held_pol;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (hold_chk) begin
        check("hold_valid", evt_valid, 1);
        check("hold_ch", evt_ch, held_ch);
        check("hold_pol", evt_pol, held_pol);
      end
`ifndef EDGE_ARB_B2B_EN
      if (hs_prev) check("bubble", evt_valid, 0);
`endif
      if (evt_valid && evt_ready) begin
        check("evt_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("evt_ch", evt_ch, e.ch);
          check("evt_pol", evt_pol, e.pol);
        end
      end
      hold_chk = evt_valid && !evt_ready;
      hs_prev  = evt_valid && evt_ready;
      held_ch  = evt_ch;
      held_pol = evt_pol;
    end else begin
      hold_chk = 1'b0;
      hs_prev  = 1'b0;
    end
  end

  initial begin
    int c;
    reset     = 1'b0;
    a_in      = 4'b0001;
    pos_en    = 4'hF;
    neg_en    = 4'hF;
    evt_ready = 1'b1;
    ovf_clr   = 4'h0;

    // Reset state with a static-high input
    repeat (3) @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_ch", evt_ch, 0);
    check("rst_pol", evt_pol, 0);
    check("rst_ovf", ovf, 0);
    tick(1);
    reset = 1'b1;
    count_valid(10, c);
    check("no_false_rise", c, 0);
    check("ovf_idle", ovf, 0);
    tick(1);

    // Falling edge on channel 0
    a_in = 4'b0000;
    push(2'd0, 1'b0);
    drain();

    // Latency: pending at edge k, valid after edge k+1
    a_in = 4'b0100;
    push(2'd2, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("lat_k", evt_valid, 0);
    @(negedge clk);
    check("lat_k1", evt_valid, 1);
    drain();
    a_in = 4'b0000;
    push(2'd2, 1'b0);
    drain();

    // Reset pulse to restart round-robin from channel 0
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);

    // Simultaneous rises: order 0, 1, 3
    a_in = 4'b1011;
    push(2'd0, 1'b1);
    push(2'd1, 1'b1);
    push(2'd3, 1'b1);
    drain();
    // Falls on 0 and 1 leave the pointer at 2
    a_in = 4'b1000;
    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    drain();
    // Channel 3 (fall) wins over channel 0 (rise), then wrap to 0
    a_in = 4'b0001;
    push(2'd3, 1'b0);
    push(2'd0, 1'b1);
    drain();

    // Overflow: rise offered, fall pending, second rise dropped
    evt_ready = 1'b0;
    a_in = 4'b0011;
    push(2'd1, 1'b1);
    push(2'd1, 1'b0);
    tick(1);
    a_in = 4'b0001;
    tick(1);
    a_in = 4'b0011;
    @(negedge clk);
    check("ovf_pre", ovf, 4'b0000);
    @(negedge clk);
    check("ovf_set", ovf, 4'b0010);
    check("offer_ch", evt_ch, 1);
    check("offer_pol", evt_pol, 1);
    tick(3);
    evt_ready = 1'b1;
    drain();
    check("ovf_sticky", ovf, 4'b0010);
    ovf_clr = 4'b0010;
    tick(1);
    ovf_clr = 4'b0000;
    @(negedge clk);
    check("ovf_clr", ovf, 4'b0000);
    tick(1);

    // Rising edge disabled on channel 0: only the fall is reported
    pos_en = 4'b1110;
    neg_en = 4'b1110;
    a_in   = 4'b0010;
    tick(3);
    neg_en = 4'hF;
    a_in   = 4'b0011;
    tick(3);
    a_in   = 4'b0010;
    push(2'd0, 1'b0);
    drain();
    pos_en = 4'hF;
    tick(2);

    // Reset while offering with two more events pending
    evt_ready = 1'b0;
    a_in = 4'b1100;
    tick(3);
    @(negedge clk);
    check("pre_rst_valid", evt_valid, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", evt_valid, 0);
    check("async_rst_ch", evt_ch, 0);
    check("async_rst_ovf", ovf, 0);
    tick(2);
    evt_ready = 1'b1;
    reset = 1'b1;
    count_valid(12, c);
    check("no_evt_after_rst", c, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Watches NUM_CH single-bit inputs and detects rising and falling edges per channel, with per-polarity enables.
- Holds one pending event per channel.
- Serialises pending events onto one valid/ready event port using round-robin arbitration.
- Sits between raw edge sources (buttons, strobes) and a single downstream event consumer, replacing per-signal edge detectors.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- IDX_W, 2, width of channel index; must be >= clog2(NUM_CH).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- a_in  in  NUM_CH  monitored inputs, synchronous to clk
- pos_en  in  NUM_CH  per-channel rising-edge enable
- neg_en  in  NUM_CH  per-channel falling-edge enable
- evt_valid  out  1  event available on evt_ch/evt_pol
- evt_ready  in  1  consumer accepts event
- evt_ch  out  IDX_W  channel index of the offered event
- evt_pol  out  1  1 = rising edge, 0 = falling edge
- ovf  out  NUM_CH  sticky per-channel overflow flags
- ovf_clr  in  NUM_CH  per-channel overflow clear, one-cycle pulse

Behaviour:
- Reset (reset=0, asynchronous): evt_valid=0, evt_ch=0, evt_pol=0, ovf=0. Internal state also resets: prev sample regs=0, pending=0, rr pointer=0, armed=0, FSM=IDLE.
- Arming:
  - The first rising clk after reset releases only loads prev<=a_in and sets armed=1. No edge is detected on that cycle.
  - A static-high input during reset therefore never produces a false rising edge.
- Edge detect (armed=1):
  - rise[i] = a_in[i] & ~prev[i] & pos_en[i]
  - fall[i] = ~a_in[i] & prev[i] & neg_en[i]
  - prev <= a_in every cycle.
- Pending: a detected edge sets pending[i]=1 and pol[i]=rise[i] at the same clock edge.
- Overflow:
  - Condition: edge detected on channel i while pending[i]=1, and channel i is not being granted that cycle.
  - Result: new edge dropped, oldest pending event kept, ovf[i]<=1.
  - If channel i is granted in the same cycle a new edge arrives, the new edge becomes pending and no overflow is flagged.
- ovf_clr[i] clears ovf[i]. When set and clear coincide, set wins.
- Disabling an enable does not flush an already-pending event.
- FSM states: IDLE, OFFER.
  - IDLE: if any pending, grant the first pending channel searching from rr pointer upward with wrap-around. On grant:
    - load evt_ch/evt_pol
    - clear pending[grant]
    - evt_valid<=1
    - rr pointer <= grant+1 (wraps to 0 after NUM_CH-1)
    - go to OFFER.
  - IDLE: if nothing is pending, stay in IDLE with evt_valid=0.
  - OFFER: evt_valid, evt_ch and evt_pol are held stable while evt_ready=0. On evt_valid&evt_ready at a clock edge: evt_valid<=0, go to IDLE.
- Latency: a_in toggles before clock edge k → pending at k → evt_valid high after edge k+1 when the arbiter is idle.
- Throughput: one event per 2 cycles (one bubble after each handshake).
- evt_ready while evt_valid=0 is ignored.
- Mid-operation reset drops all pending events and the event currently offered. Arming repeats after release.

Optional Feature:
- Macro: EDGE_ARB_B2B_EN.
- Defined: in OFFER, a handshake with any channel pending performs the IDLE grant in the same cycle. evt_valid stays 1 with new evt_ch/evt_pol, giving one event per cycle. The FSM returns to IDLE only when nothing is pending.
- Undefined: behaviour as above, with the mandatory bubble cycle.

Test Plan:
- Hold a_in=4'b0001, pos_en=neg_en=4'hF through reset and release → no event for 10 cycles; ovf=0.
- Pulse a_in[2] 0→1 with evt_ready=1 → evt_valid=1 two cycles after sampling, evt_ch=2, evt_pol=1. Then a_in[2] 1→0 → evt_ch=2, evt_pol=0.
- Rise channels 0, 1, 3 in the same cycle with evt_ready=1 → grants in order 0, 1, 3, with evt_valid low one cycle between grants. A subsequent rise on channel 0 is granted after channel 3 wrap-around.
- evt_ready=0; toggle a_in[1] 0→1→0→1 on consecutive cycles:
  - First event offered and held stable.
  - Second (fall) becomes pending.
  - Third (rise) drops and sets ovf[1]=1.
  - After raising evt_ready: events delivered are rise, then fall.
  - Then pulse ovf_clr[1] → ovf[1]=0.
- pos_en[0]=0, neg_en[0]=1; rise then fall on a_in[0] → only one event delivered, ch=0, pol=0.
- Assert reset while evt_valid=1 and two events pending → evt_valid=0 immediately and pending cleared. After release, no events appear without new edges.
